pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Sequencing and hazard controller for the 5-stage MIPS pipeline.
- Drives enable and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Supports continuous-run and single-step execution under debug-unit control, inserts load-use bubbles, squashes wrong-path fetches on taken branch/jump, and drains the pipeline on HALT before reporting halted.

Parameters:
- REG_ADDR_SIZE, 5, width of register specifiers.
- COUNTER_SIZE, 32, width of executed-cycle counter.
- DRAIN_CYCLES, 3, cycles needed after HALT decode for the HALT to leave MEM/WB (ID/EX→EX/MEM→MEM/WB).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_run  in  1  pulse: enter continuous mode.
- i_step  in  1  pulse: advance pipeline exactly one cycle.
- i_stop  in  1  pulse: abort run/step, return to IDLE, state preserved.
- i_halt_id  in  1  HALT opcode present in ID stage.
- i_id_ex_mem_read  in  1  instruction in ID/EX is a load.
- i_id_ex_rt  in  REG_ADDR_SIZE  load destination in ID/EX.
- i_if_id_rs  in  REG_ADDR_SIZE  rs of instruction in ID.
- i_if_id_rt  in  REG_ADDR_SIZE  rt of instruction in ID.
- i_branch_taken  in  1  taken branch or jump resolved in ID.
- o_pc_enable  out  1  PC update enable.
- o_if_id_enable  out  1  IF/ID enable.
- o_id_ex_enable  out  1  ID/EX enable.
- o_ex_mem_enable  out  1  EX/MEM enable.
- o_mem_wb_enable  out  1  MEM/WB enable.
- o_if_id_flush  out  1  clear IF/ID.
- o_id_ex_flush  out  1  clear ID/EX (bubble).
- o_halted  out  1  program finished, pipeline drained.
- o_cycle_count  out  COUNTER_SIZE  number of advance cycles since reset.

Behaviour:
- States:
  - IDLE: nothing advances.
  - RUN: advance every cycle.
  - STEP: advance one cycle, then return to IDLE.
  - DRAIN: PC and IF/ID frozen, rest advance.
  - HALTED: terminal until reset.
  - State register and drain counter are async-reset to IDLE/0.
- Reset:
  - o_cycle_count = 0, o_halted = 0.
  - All enables and flushes = 0 while i_reset is high.
  - Reset mid-run or mid-drain aborts immediately to IDLE.
- Transitions:
  - IDLE + i_run → RUN; IDLE + i_step → STEP; i_run takes priority if both are asserted.
  - STEP → IDLE after one cycle.
  - RUN or STEP + i_stop → IDLE; that cycle does not advance.
  - RUN or STEP + i_halt_id (on an advancing cycle) → DRAIN; drain counter loads DRAIN_CYCLES-1.
  - DRAIN decrements on each advancing cycle; at 0 with advance → HALTED.
  - In step mode (entered via i_step), DRAIN advances only on i_step pulses and returns to DRAIN (not IDLE) between pulses.
  - HALTED ignores i_run, i_step and i_stop; o_halted = 1.
- "adv" is high in RUN, in STEP, and in DRAIN when running continuously or when i_step is high.
- Enables (combinational from state and hazard inputs):
  - ex_mem and mem_wb enables = adv.
  - id_ex enable = adv.
  - pc and if_id enables = adv & ~load_use & state≠DRAIN.
- load_use = i_id_ex_mem_read & (i_id_ex_rt≠0) & (i_id_ex_rt==i_if_id_rs | i_id_ex_rt==i_if_id_rt).
- Flushes:
  - o_id_ex_flush = adv & load_use.
  - o_if_id_flush = adv & i_branch_taken & ~load_use & state≠DRAIN.
  - Load-use has priority over branch: the branch is re-evaluated next cycle with operands available.
  - i_halt_id together with load_use: the stall takes effect, the HALT stays in ID, and the DRAIN transition is deferred until load_use clears.
- Flush outputs are combinational and are sampled by the pipeline registers at the same clock edge.
- o_cycle_count increments by 1 on every adv cycle, including stall cycles. It wraps modulo 2^COUNTER_SIZE and holds in IDLE and HALTED.

Test Plan:
- Reset then i_run, no hazards, 10 cycles → all enables 1, flushes 0, o_cycle_count=10. Assert i_reset mid-run → count 0, enables 0 in the same cycle.
- RUN with i_id_ex_mem_read=1, i_id_ex_rt=5, i_if_id_rs=5 for one cycle → pc/if_id enables 0, o_id_ex_flush=1, ex_mem/mem_wb enables 1. Repeat with i_id_ex_rt=0 → no stall.
- RUN with i_branch_taken=1 → o_if_id_flush=1 for one cycle, pc enable 1. Same cycle with load_use=1 → o_if_id_flush=0, o_id_ex_flush=1.
- RUN, i_halt_id=1 → next 3 cycles pc/if_id enables 0, ex_mem enable 1; then o_halted=1, all enables 0, o_cycle_count frozen. Later i_run pulse → no change.
- IDLE, three i_step pulses separated by 4 idle cycles → exactly three single-cycle advance windows, o_cycle_count=3.
- RUN then i_stop → enables 0 the same cycle, state IDLE. A subsequent i_step advances once.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control/status bundle between the debug unit + hazard sources and the
// pipeline sequencing controller. The master drives the requests and hazard
// inputs; the slave (the controller) drives enables, flushes and status.
// Handshake semantics: i_run, i_step and i_stop are single-cycle level pulses
// sampled on the rising clock edge. There is no ready/acknowledge path, and a
// pulse that arrives in a state that ignores it is simply dropped.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_SIZE = 5,
  parameter int COUNTER_SIZE  = 32
);
  logic                     i_run;
  logic                     i_step;
  logic                     i_stop;
  logic                     i_halt_id;
  logic                     i_id_ex_mem_read;
  logic [REG_ADDR_SIZE-1:0] i_id_ex_rt;
  logic [REG_ADDR_SIZE-1:0] i_if_id_rs;
  logic [REG_ADDR_SIZE-1:0] i_if_id_rt;
  logic                     i_branch_taken;
  logic                     o_pc_enable;
  logic                     o_if_id_enable;
  logic                     o_id_ex_enable;
  logic                     o_ex_mem_enable;
  logic                     o_mem_wb_enable;
  logic                     o_if_id_flush;
  logic                     o_id_ex_flush;
  logic                     o_halted;
  logic [COUNTER_SIZE-1:0]  o_cycle_count;

  modport master (
    output i_run, i_step, i_stop, i_halt_id, i_id_ex_mem_read,
           i_id_ex_rt, i_if_id_rs, i_if_id_rt, i_branch_taken,
    input  o_pc_enable, o_if_id_enable, o_id_ex_enable, o_ex_mem_enable,
           o_mem_wb_enable, o_if_id_flush, o_id_ex_flush, o_halted,
           o_cycle_count
  );

  modport slave (
    input  i_run, i_step, i_stop, i_halt_id, i_id_ex_mem_read,
           i_id_ex_rt, i_if_id_rs, i_if_id_rt, i_branch_taken,
    output o_pc_enable, o_if_id_enable, o_id_ex_enable, o_ex_mem_enable,
           o_mem_wb_enable, o_if_id_flush, o_id_ex_flush, o_halted,
           o_cycle_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the 5-stage MIPS pipeline: run/step
// control from the debug unit, load-use bubbles, wrong-path squash on taken
// branches, and a HALT drain that reports halted once MEM/WB is clear.
module pipeline_ctrl #(
  parameter int REG_ADDR_SIZE = 5,
  parameter int COUNTER_SIZE  = 32,
  parameter int DRAIN_CYCLES  = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pipeline_ctrl_if.slave     bus,
  output logic [2:0]         o_state
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                    step_mode_q, step_mode_d;
  logic [COUNTER_SIZE-1:0] cycle_count_q, cycle_count_d;

  logic load_use;
  logic adv;
  logic in_drain;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = bus.i_id_ex_mem_read && (bus.i_id_ex_rt != '0) &&
               ((bus.i_id_ex_rt == bus.i_if_id_rs) ||
                (bus.i_id_ex_rt == bus.i_if_id_rt));
  end

  // Advance qualifier. A stop request suppresses the advance in its own cycle;
  // a step-mode drain only moves on a step pulse. Reset forces everything off.
  always_comb begin
    adv = 1'b0;
    case (state_q)
      S_RUN, S_STEP: adv = !bus.i_stop;
      S_DRAIN:       adv = !step_mode_q || bus.i_step;
      default:       adv = 1'b0;
    endcase
    adv      = adv && !i_reset;
    in_drain = (state_q == S_DRAIN);
  end

  // Next-state, drain counter and cycle counter.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    step_mode_d   = step_mode_q;
    cycle_count_d = cycle_count_q + COUNTER_SIZE'(adv);
    case (state_q)
      S_IDLE: begin
        if (bus.i_run)       state_d = S_RUN;
        else if (bus.i_step) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else if (bus.i_halt_id && !load_use) begin
          // HALT leaves ID this cycle; a stalled HALT waits in ID instead.
          state_d     = S_DRAIN;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
          step_mode_d = (state_q == S_STEP);
        end else if (state_q == S_STEP) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (adv) begin
          if (drain_cnt_q == '0) state_d = S_HALTED;
          else                   drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, drain counter and cycle counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= '0;
      step_mode_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      step_mode_q   <= step_mode_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Enables and flushes. Load-use outranks a taken branch: the branch is
  // re-resolved next cycle once the loaded operand is forwarded.
  always_comb begin
    bus.o_ex_mem_enable = adv;
    bus.o_mem_wb_enable = adv;
    bus.o_id_ex_enable  = adv;
    bus.o_pc_enable     = adv && !load_use && !in_drain;
    bus.o_if_id_enable  = adv && !load_use && !in_drain;
    bus.o_id_ex_flush   = adv && load_use;
    bus.o_if_id_flush   = adv && bus.i_branch_taken && !load_use && !in_drain;
    bus.o_halted        = (state_q == S_HALTED);
    bus.o_cycle_count   = cycle_count_q;
    o_state             = state_q;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Inputs change on the falling edge;
// outputs are sampled 1ns later, well clear of the rising edge.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_SIZE(5), .COUNTER_SIZE(32)) bus ();
  logic [2:0] dbg_state;

  pipeline_ctrl #(.REG_ADDR_SIZE(5), .COUNTER_SIZE(32), .DRAIN_CYCLES(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_DRAIN = 3'd3, S_HALTED = 3'd4;

  // {pc, if_id, id_ex, ex_mem, mem_wb} and {if_id_flush, id_ex_flush}
  wire [4:0] en = {bus.o_pc_enable, bus.o_if_id_enable, bus.o_id_ex_enable,
                   bus.o_ex_mem_enable, bus.o_mem_wb_enable};
  wire [1:0] fl = {bus.o_if_id_flush, bus.o_id_ex_flush};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic clear_inputs();
    bus.i_run = 0; bus.i_step = 0; bus.i_stop = 0; bus.i_halt_id = 0;
    bus.i_id_ex_mem_read = 0; bus.i_id_ex_rt = '0; bus.i_if_id_rs = '0;
    bus.i_if_id_rt = '0; bus.i_branch_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); rst = 0;
  endtask

  task automatic start_run();
    do_reset();
    bus.i_run = 1;
    @(negedge clk); bus.i_run = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; clear_inputs(); #1;
    n_tests++; if (en !== 5'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=%b", en, 5'b0); end
    n_tests++; if (fl !== 2'b0) begin n_fail++; $display("FAIL reset_fl got=%b exp=%b", fl, 2'b0); end
    n_tests++; if (bus.o_cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.o_cycle_count); end
    n_tests++; if (bus.o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", bus.o_halted); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_run();
    do_reset();
    bus.i_run = 1; #1;
    n_tests++; if (en !== 5'b0) begin n_fail++; $display("FAIL run_req_en got=%b exp=%b", en, 5'b0); end
    @(negedge clk); bus.i_run = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++; if (en !== 5'b11111 || fl !== 2'b00) begin n_fail++; $display("FAIL run_cycle%0d got en=%b fl=%b exp en=11111 fl=00", i, en, fl); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (bus.o_cycle_count !== 32'd10) begin n_fail++; $display("FAIL run_count got=%0d exp=10", bus.o_cycle_count); end
    rst = 1; #1;
    n_tests++; if (bus.o_cycle_count !== 32'd0 || en !== 5'b0) begin n_fail++; $display("FAIL midrun_reset got count=%0d en=%b exp count=0 en=00000", bus.o_cycle_count, en); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL midrun_reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_load_use();
    start_run();
    bus.i_id_ex_mem_read = 1; bus.i_id_ex_rt = 5'd5; bus.i_if_id_rs = 5'd5; bus.i_if_id_rt = 5'd7; #1;
    n_tests++; if (en !== 5'b00111 || fl !== 2'b01) begin n_fail++; $display("FAIL lu_rs got en=%b fl=%b exp en=00111 fl=01", en, fl); end
    @(negedge clk); bus.i_id_ex_rt = 5'd0; bus.i_if_id_rs = 5'd0; #1;
    n_tests++; if (en !== 5'b11111 || fl !== 2'b00) begin n_fail++; $display("FAIL lu_r0 got en=%b fl=%b exp en=11111 fl=00", en, fl); end
    @(negedge clk); bus.i_id_ex_rt = 5'd9; bus.i_if_id_rt = 5'd9; bus.i_if_id_rs = 5'd3; #1;
    n_tests++; if (en !== 5'b00111 || fl !== 2'b01) begin n_fail++; $display("FAIL lu_rt got en=%b fl=%b exp en=00111 fl=01", en, fl); end
    @(negedge clk); clear_inputs(); #1;
    n_tests++; if (bus.o_cycle_count !== 32'd3) begin n_fail++; $display("FAIL lu_count got=%0d exp=3", bus.o_cycle_count); end
  endtask

  task automatic test_branch();
    start_run();
    bus.i_branch_taken = 1; #1;
    n_tests++; if (en !== 5'b11111 || fl !== 2'b10) begin n_fail++; $display("FAIL br_flush got en=%b fl=%b exp en=11111 fl=10", en, fl); end
    @(negedge clk); bus.i_id_ex_mem_read = 1; bus.i_id_ex_rt = 5'd4; bus.i_if_id_rs = 5'd4; #1;
    n_tests++; if (en !== 5'b00111 || fl !== 2'b01) begin n_fail++; $display("FAIL br_lu_prio got en=%b fl=%b exp en=00111 fl=01", en, fl); end
    @(negedge clk); clear_inputs(); #1;
    n_tests++; if (fl !== 2'b00) begin n_fail++; $display("FAIL br_clear got fl=%b exp=00", fl); end
  endtask

  task automatic test_halt();
    start_run();
    bus.i_halt_id = 1; bus.i_id_ex_mem_read = 1; bus.i_id_ex_rt = 5'd6; bus.i_if_id_rs = 5'd6; #1;
    n_tests++; if (en !== 5'b00111) begin n_fail++; $display("FAIL halt_lu_en got=%b exp=00111", en); end
    @(negedge clk); bus.i_id_ex_mem_read = 0; #1;
    n_tests++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL halt_deferred got=%0d exp=%0d", dbg_state, S_RUN); end
    n_tests++; if (en !== 5'b11111) begin n_fail++; $display("FAIL halt_adv_en got=%b exp=11111", en); end
    @(negedge clk); clear_inputs(); bus.i_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (en !== 5'b00111 || fl !== 2'b00 || dbg_state !== S_DRAIN) begin n_fail++; $display("FAIL drain%0d got en=%b fl=%b st=%0d exp en=00111 fl=00 st=3", i, en, fl, dbg_state); end
      @(negedge clk);
    end
    bus.i_branch_taken = 0; #1;
    n_tests++; if (bus.o_halted !== 1'b1 || en !== 5'b0) begin n_fail++; $display("FAIL halted got halted=%b en=%b exp halted=1 en=00000", bus.o_halted, en); end
    n_tests++; if (bus.o_cycle_count !== 32'd5) begin n_fail++; $display("FAIL halt_count got=%0d exp=5", bus.o_cycle_count); end
    bus.i_run = 1; bus.i_step = 1; bus.i_stop = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); #1;
    n_tests++; if (dbg_state !== S_HALTED || bus.o_cycle_count !== 32'd5 || en !== 5'b0) begin n_fail++; $display("FAIL halt_sticky got st=%0d count=%0d en=%b exp st=4 count=5 en=00000", dbg_state, bus.o_cycle_count, en); end
  endtask

  task automatic test_step();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      bus.i_step = 1; #1;
      n_tests++; if (en !== 5'b0) begin n_fail++; $display("FAIL step%0d_req got en=%b exp=00000", p, en); end
      @(negedge clk); bus.i_step = 0; #1;
      n_tests++; if (en !== 5'b11111 || dbg_state !== S_STEP) begin n_fail++; $display("FAIL step%0d_adv got en=%b st=%0d exp en=11111 st=2", p, en, dbg_state); end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); #1;
        n_tests++; if (en !== 5'b0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL step%0d_idle%0d got en=%b st=%0d exp en=00000 st=0", p, k, en, dbg_state); end
      end
      @(negedge clk);
    end
    #1;
    n_tests++; if (bus.o_cycle_count !== 32'd3) begin n_fail++; $display("FAIL step_count got=%0d exp=3", bus.o_cycle_count); end
  endtask

  task automatic test_stop();
    start_run();
    @(negedge clk); bus.i_stop = 1; bus.i_branch_taken = 1; #1;
    n_tests++; if (en !== 5'b0 || fl !== 2'b0) begin n_fail++; $display("FAIL stop_same_cycle got en=%b fl=%b exp en=00000 fl=00", en, fl); end
    @(negedge clk); clear_inputs(); #1;
    n_tests++; if (dbg_state !== S_IDLE || bus.o_cycle_count !== 32'd1) begin n_fail++; $display("FAIL stop_idle got st=%0d count=%0d exp st=0 count=1", dbg_state, bus.o_cycle_count); end
    bus.i_step = 1;
    @(negedge clk); bus.i_step = 0; #1;
    n_tests++; if (en !== 5'b11111 || dbg_state !== S_STEP) begin n_fail++; $display("FAIL stop_then_step got en=%b st=%0d exp en=11111 st=2", en, dbg_state); end
    @(negedge clk); #1;
    n_tests++; if (dbg_state !== S_IDLE || bus.o_cycle_count !== 32'd2) begin n_fail++; $display("FAIL stop_step_done got st=%0d count=%0d exp st=0 count=2", dbg_state, bus.o_cycle_count); end
  endtask

  task automatic test_step_drain();
    do_reset();
    bus.i_step = 1;
    @(negedge clk); bus.i_step = 0; bus.i_halt_id = 1; #1;
    n_tests++; if (en !== 5'b11111 || dbg_state !== S_STEP) begin n_fail++; $display("FAIL sd_step got en=%b st=%0d exp en=11111 st=2", en, dbg_state); end
    @(negedge clk); bus.i_halt_id = 0; #1;
    n_tests++; if (en !== 5'b0 || dbg_state !== S_DRAIN) begin n_fail++; $display("FAIL sd_wait got en=%b st=%0d exp en=00000 st=3", en, dbg_state); end
    @(negedge clk); #1;
    n_tests++; if (dbg_state !== S_DRAIN) begin n_fail++; $display("FAIL sd_hold got st=%0d exp=3", dbg_state); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.i_step = 1; #1;
      n_tests++; if (en !== 5'b00111) begin n_fail++; $display("FAIL sd_pulse%0d got en=%b exp=00111", i, en); end
      @(negedge clk); bus.i_step = 0; #1;
      n_tests++; if (en !== 5'b0 || dbg_state !== ((i == 2) ? S_HALTED : S_DRAIN)) begin n_fail++; $display("FAIL sd_after%0d got en=%b st=%0d", i, en, dbg_state); end
    end
    n_tests++; if (bus.o_cycle_count !== 32'd4 || bus.o_halted !== 1'b1) begin n_fail++; $display("FAIL sd_final got count=%0d halted=%b exp count=4 halted=1", bus.o_cycle_count, bus.o_halted); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_halt();
    test_step();
    test_stop();
    test_step_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
